// File: rtl/hdc_stream_encoder.sv
// hdc_stream_encoder: quantises a multi-channel sample and streams its item-memory level
// hypervectors one channel per cycle, or ORs them into a single bundle.
module hdc_stream_encoder #(
  parameter int CHANNELS = 11,
  parameter int DIM = 5000,
  parameter int LEVELS = 10,
  parameter int IN_W = 32,
  parameter int QSHIFT = 28,
  parameter int LVL_W = $clog2(LEVELS),
  parameter int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS*IN_W-1:0] in_data,
  input  logic                     in_mode,
  input  logic                     im_we,
  input  logic [LVL_W-1:0]         im_addr,
  input  logic [DIM-1:0]           im_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM-1:0]           out_hv,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [LVL_W-1:0] q [CHANNELS];
  logic [LVL_W-1:0] lvl [CHANNELS];
  logic [DIM-1:0] im [LEVELS];
  logic [DIM-1:0] acc, rd;
  logic [CH_W-1:0] ch;
  logic mode, accept, step, last_ch;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_q
    logic [IN_W-1:0] s;
    assign s = in_data[i*IN_W +: IN_W] >> QSHIFT;
    assign q[i] = s > IN_W'(LEVELS-1) ? LVL_W'(LEVELS-1) : s[LVL_W-1:0];
  end
  assign in_ready = state == IDLE;
  assign accept = in_ready && in_valid;
  assign step = state == RUN && (!out_valid || out_ready);
  assign last_ch = ch == CH_W'(CHANNELS-1);
  assign rd = im[lvl[ch]];
  always_comb begin
    state_n = accept ? RUN : (step && last_ch) ? IDLE : state;
  end
  // Out-of-range addresses are dropped so non-power-of-two depths never alias.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int k = 0; k < LEVELS; k++) im[k] <= '0;
    end else if (im_we && int'(im_addr) < LEVELS) begin
      im[im_addr] <= im_wdata;
    end
  end
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state <= IDLE;
      for (int c = 0; c < CHANNELS; c++) lvl[c] <= '0;
      mode <= 1'b0;
      ch <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_hv <= '0;
      out_ch <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        lvl <= q;
        mode <= in_mode;
        ch <= '0;
        acc <= '0;
      end else if (step) begin
        ch <= last_ch ? '0 : ch + CH_W'(1);
        if (mode && !last_ch) acc <= acc | rd;
      end
      if (step && (!mode || last_ch)) begin
        out_hv <= mode ? acc | rd : rd;
        out_ch <= ch;
        out_last <= last_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hdc_stream_encoder.sv
// tb_hdc_stream_encoder: directed scoreboard bench for a 4-channel, 16-bit, 4-level encoder.
module tb_hdc_stream_encoder;
  logic clk = 0, nrst = 0, in_valid = 0, in_mode = 0, im_we = 0, out_ready = 1;
  logic [31:0] in_data = '0;
  logic [2:0] im_addr = '0;
  logic [15:0] im_wdata = '0;
  logic in_ready, out_valid, out_last;
  logic [15:0] out_hv;
  logic [1:0] out_ch;
  logic [18:0] sb [$];
  logic [15:0] im_m [4] = '{default: '0};
  int n_chk = 0, n_fail = 0, n;

  hdc_stream_encoder #(.CHANNELS(4), .DIM(16), .LEVELS(4), .IN_W(8), .QSHIFT(4), .LVL_W(3)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_hv(out_hv), .out_ch(out_ch),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [31:0] d, input logic m);
    logic [15:0] acc = '0;
    int q;
    for (int c = 0; c < 4; c++) begin
      q = int'(d[c*8 +: 8]) >> 4;
      if (q > 3) q = 3;
      if (m) acc |= im_m[q];
      else sb.push_back({im_m[q], 2'(c), c == 3});
    end
    if (m) sb.push_back({acc, 2'd3, 1'b1});
  endtask

  always @(negedge clk) begin
    if (!nrst && out_valid && out_ready) begin
      chk("beat_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("beat", {13'b0, out_hv, out_ch, out_last}, 32'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 nrst = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_hv", out_hv, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_last", out_last, 0);
    nrst = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      im_we = 1;
      im_addr = 3'(k);
      im_wdata = 16'h0001 << (4 * k);
      im_m[k] = im_wdata;
      tick;
    end
    im_we = 0;
    // mode 0, saturating sample, free-flowing output
    in_data = 32'hFF351000;
    in_mode = 0;
    in_valid = 1;
    chk("m0_in_ready", in_ready, 1);
    push_sample(in_data, 0);
    tick;
    in_valid = 0;
    chk("m0_busy", in_ready, 0);
    chk("m0_no_beat_at_accept", out_valid, 0);
    tick;
    chk("m0_first_beat", out_valid, 1);
    chk("m0_first_ch", out_ch, 0);
    repeat (3) tick;
    chk("m0_last_ch", out_ch, 3);
    chk("m0_last_flag", out_last, 1);
    tick;
    chk("m0_done", out_valid, 0);
    chk("m0_idle", in_ready, 1);
    // mode 0 with a 3-cycle stall on beat 1
    in_valid = 1;
    push_sample(in_data, 0);
    tick;
    in_valid = 0;
    tick;
    tick;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_hv", out_hv, 16'h0010);
      chk("bp_ch", out_ch, 1);
      tick;
    end
    out_ready = 1;
    repeat (4) tick;
    chk("bp_done", out_valid, 0);
    chk("bp_drained", sb.size(), 0);
    // mode 1 back-to-back bundles
    in_mode = 1;
    in_valid = 1;
    push_sample(in_data, 1);
    tick;
    in_data = 32'h052F2530;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("m1_latency", n, 4);
    chk("m1_last", out_last, 1);
    chk("m1_ready_again", in_ready, 1);
    push_sample(in_data, 1);
    tick;
    in_valid = 0;
    chk("m1_second_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("m1_latency2", n, 4);
    tick;
    chk("m1_done", out_valid, 0);
    chk("m1_drained", sb.size(), 0);
    // item-memory write lands between the ch1 and ch2 steps
    in_mode = 0;
    in_data = 32'hFF351000;
    in_valid = 1;
    sb.push_back({16'h0001, 2'd0, 1'b0});
    sb.push_back({16'h0010, 2'd1, 1'b0});
    sb.push_back({16'hBEEF, 2'd2, 1'b0});
    sb.push_back({16'hBEEF, 2'd3, 1'b1});
    tick;
    in_valid = 0;
    tick;
    im_we = 1;
    im_addr = 3;
    im_wdata = 16'hBEEF;
    tick;
    im_we = 0;
    im_m[3] = 16'hBEEF;
    repeat (3) tick;
    chk("imw_done", out_valid, 0);
    chk("imw_drained", sb.size(), 0);
    im_we = 1;
    im_addr = 5;
    im_wdata = 16'hFFFF;
    tick;
    im_we = 0;
    in_data = 32'h30201000;
    in_valid = 1;
    push_sample(in_data, 0);
    tick;
    in_valid = 0;
    in_mode = 1;
    repeat (5) tick;
    in_data = 32'hFF351000;
    in_valid = 1;
    push_sample(in_data, 1);
    tick;
    in_valid = 0;
    repeat (5) tick;
    chk("oor_drained", sb.size(), 0);
    // asynchronous reset in the middle of a stalled sample
    out_ready = 0;
    in_mode = 0;
    in_valid = 1;
    tick;
    in_valid = 0;
    repeat (2) tick;
    chk("mid_held_valid", out_valid, 1);
    chk("mid_held_hv", out_hv, 16'h0001);
    #2;
    nrst = 1;
    sb.delete();
    for (int k = 0; k < 4; k++) im_m[k] = '0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_hv", out_hv, 0);
    chk("mid_rst_ch", out_ch, 0);
    chk("mid_rst_last", out_last, 0);
    #2;
    nrst = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1;
    in_data = 32'h0;
    in_valid = 1;
    push_sample(in_data, 0);
    tick;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("post_rst_latency", n, 1);
    chk("post_rst_im0", out_hv, 0);
    repeat (6) tick;
    chk("end_drained", sb.size(), 0);
    chk("end_idle", out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
